// File: rtl/task_framer_pkg.sv
// Shared types and constants for the task answer UART framer.
package task_framer_pkg;

   typedef enum logic [2:0] {
      COLLECT,
      LATCH,
      HDR,
      PAYLOAD,
      CSUM,
      DONE
   } state_e;

   localparam int         HDR_BYTES          = 9;
   localparam logic [3:0] HDR_LAST_IDX       = 4'(HDR_BYTES - 1);
   localparam logic [7:0] DEFAULT_START_BYTE = 8'hA5;

endpackage

// File: rtl/framer_word_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a push on a
// full FIFO succeeds when a pop happens in the same cycle.
module framer_word_fifo #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       push_ok,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;

   assign pop_ok   = pop && (count != '0);
   assign push_ok  = push && ((count != (AW+1)'(DEPTH)) || pop_ok);
   assign pop_data = mem[rd_ptr];

   // NOTE: storage has no reset; pointers and count define validity, and a
   // resettable array would cost a reset mux per bit for no functional gain.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/task_answer_uart_framer.sv
// Buffers answer words and emits one byte-serial frame per answer to UART TX.
// Define TASK_FRAMER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module task_answer_uart_framer
   import task_framer_pkg::*;
#(
   parameter int         FIFO_DEPTH = 256,
   parameter logic [7:0] START_BYTE = DEFAULT_START_BYTE
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_answer_valid,
   input  logic [31:0] i_answer_data,
   input  logic        i_answer_last,
   input  logic [31:0] i_answer_size_in_bytes,
   input  logic [31:0] i_answer_latency,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic        o_overflow,
   output logic        o_frame_done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef TASK_FRAMER_CHECKSUM_EN
   localparam state_e TAIL_STATE = CSUM;
`else
   localparam state_e TAIL_STATE = DONE;
`endif

   state_e          state_q, state_d;
   logic [31:0]     size_q, lat_q, bytes_left, size_clamped, words_bytes;
   logic [CW-1:0]   cur_words, next_words, words_left, fifo_count;
   logic [3:0]      hdr_idx;
   logic [1:0]      bsel;
   logic [71:0]     hdr_vec;
   logic [31:0]     fifo_rd_data;
   logic            fifo_push_ok, fifo_pop, fifo_empty;
   logic            tx_free, have_byte, load;
   logic [7:0]      byte_d;
`ifdef TASK_FRAMER_CHECKSUM_EN
   logic [7:0]      csum_q;
`endif

   framer_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (i_answer_valid),
      .push_data (i_answer_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .push_ok   (fifo_push_ok),
      .count     (fifo_count)
   );

   assign o_busy       = (state_q != COLLECT);
   assign fifo_empty   = (fifo_count == '0);
   assign tx_free      = !o_tx_valid || i_tx_ready;
   assign hdr_vec      = {lat_q, size_q, START_BYTE};
   assign words_bytes  = 32'(cur_words) << 2;
   assign size_clamped = (i_answer_size_in_bytes > words_bytes) ? words_bytes
                                                                : i_answer_size_in_bytes;

   // NOTE: every combinational output gets a default first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      have_byte = 1'b0;
      byte_d    = '0;
      fifo_pop  = 1'b0;
      case (state_q)
         COLLECT: if (i_answer_valid && i_answer_last) state_d = LATCH;
         LATCH:   state_d = HDR;
         HDR: begin
            have_byte = 1'b1;
            byte_d    = hdr_vec[{hdr_idx, 3'b000} +: 8];
            if (tx_free && hdr_idx == HDR_LAST_IDX)
               state_d = (size_q != '0 || words_left != '0) ? PAYLOAD : TAIL_STATE;
         end
         PAYLOAD: begin
            if (bytes_left != '0) begin
               have_byte = !fifo_empty;
               byte_d    = fifo_rd_data[{bsel, 3'b000} +: 8];
               fifo_pop  = have_byte && tx_free && (bsel == 2'd3 || bytes_left == 32'd1);
            end else if (words_left != '0) begin
               // Surplus words beyond the clamped size are dropped here.
               fifo_pop = !fifo_empty;
            end else begin
               state_d = TAIL_STATE;
            end
         end
`ifdef TASK_FRAMER_CHECKSUM_EN
         CSUM: begin
            have_byte = 1'b1;
            byte_d    = csum_q;
            if (tx_free) state_d = DONE;
         end
`endif
         DONE:    if (tx_free) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
      load = have_byte && tx_free;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= COLLECT;
         o_tx_data    <= '0;
         o_tx_valid   <= 1'b0;
         o_frame_done <= 1'b0;
         o_overflow   <= 1'b0;
         size_q       <= '0;
         lat_q        <= '0;
         bytes_left   <= '0;
         words_left   <= '0;
         cur_words    <= '0;
         next_words   <= '0;
         hdr_idx      <= '0;
         bsel         <= '0;
      end else begin
         state_q      <= state_d;
         o_frame_done <= (state_q == DONE) && tx_free;

         if (load) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= byte_d;
         end else if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
         end

         if ((i_answer_valid && !fifo_push_ok) ||
             (i_answer_valid && i_answer_last && o_busy))
            o_overflow <= 1'b1;

         // Words arriving mid-frame belong to the next answer.
         if (state_q == COLLECT) begin
            cur_words <= cur_words + CW'(fifo_push_ok);
         end else if (state_q == DONE && tx_free) begin
            cur_words  <= next_words + CW'(fifo_push_ok);
            next_words <= '0;
         end else begin
            next_words <= next_words + CW'(fifo_push_ok);
         end

         if (state_q == LATCH) begin
            size_q     <= size_clamped;
            lat_q      <= i_answer_latency;
            bytes_left <= size_clamped;
            words_left <= cur_words;
            hdr_idx    <= '0;
            bsel       <= '0;
         end

         if (load && state_q == HDR) hdr_idx <= hdr_idx + 4'd1;

         if (load && state_q == PAYLOAD) bytes_left <= bytes_left - 32'd1;

         if (fifo_pop) begin
            words_left <= words_left - CW'(1);
            bsel       <= '0;
         end else if (load && state_q == PAYLOAD) begin
            bsel <= bsel + 2'd1;
         end
      end
   end

`ifdef TASK_FRAMER_CHECKSUM_EN
   always_ff @(posedge i_clk) begin
      if (i_rst || state_q == LATCH)
         csum_q <= '0;
      else if (load && (state_q == PAYLOAD || (state_q == HDR && hdr_idx != '0)))
         csum_q <= csum_q ^ byte_d;
   end
`endif

endmodule

// File: tb/tb_task_answer_uart_framer.sv
// Scoreboard bench: stimulus queues expected frame bytes, a monitor pops and
// compares each accepted TX byte. Two DUTs share stimulus: depth 256 and 4.
module tb_task_answer_uart_framer;

   logic        clk, rst, sel, toggle;
   logic        ans_valid, ans_last, tx_ready;
   logic [31:0] ans_data, ans_size, ans_lat;

   logic [7:0]  a_tx_data, b_tx_data, m_tx_data;
   logic        a_tx_valid, a_busy, a_ovf, a_done;
   logic        b_tx_valid, b_busy, b_ovf, b_done;
   logic        m_tx_valid, m_busy, m_ovf, m_done;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   logic [7:0]  sb[$];
   logic [31:0] wq[$];

   task_answer_uart_framer #(.FIFO_DEPTH(256)) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_answer_valid(ans_valid && !sel), .i_answer_data(ans_data),
      .i_answer_last(ans_last), .i_answer_size_in_bytes(ans_size),
      .i_answer_latency(ans_lat),
      .o_tx_data(a_tx_data), .o_tx_valid(a_tx_valid), .i_tx_ready(tx_ready),
      .o_busy(a_busy), .o_overflow(a_ovf), .o_frame_done(a_done)
   );

   task_answer_uart_framer #(.FIFO_DEPTH(4)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_answer_valid(ans_valid && sel), .i_answer_data(ans_data),
      .i_answer_last(ans_last), .i_answer_size_in_bytes(ans_size),
      .i_answer_latency(ans_lat),
      .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid), .i_tx_ready(tx_ready),
      .o_busy(b_busy), .o_overflow(b_ovf), .o_frame_done(b_done)
   );

   assign m_tx_data  = sel ? b_tx_data  : a_tx_data;
   assign m_tx_valid = sel ? b_tx_valid : a_tx_valid;
   assign m_busy     = sel ? b_busy     : a_busy;
   assign m_ovf      = sel ? b_ovf      : a_ovf;
   assign m_done     = sel ? b_done     : a_done;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "simulation timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Ready pattern 1-0-0-1 while toggle is set.
   initial begin
      int ph = 0;
      logic [3:0] pat = 4'b1001;
      forever begin
         @(posedge clk);
         #2;
         if (toggle) begin
            tx_ready = pat[3-ph];
            ph = (ph + 1) % 4;
         end
      end
   end

   // Monitor: compare every accepted byte; check hold during stalls.
   initial begin
      logic       prev_stall = 1'b0;
      logic [7:0] prev_data  = '0;
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", m_tx_valid, 1'b1);
               check("hold_data", m_tx_data, prev_data);
            end
            if (m_tx_valid && tx_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_byte", m_tx_data, 32'hFFFF_FFFF);
               end else begin
                  exp = sb.pop_front();
                  check("tx_byte", m_tx_data, exp);
               end
            end
            prev_stall = m_tx_valid && !tx_ready;
            prev_data  = m_tx_data;
            if (m_done) done_cnt++;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      ans_valid = 1'b0;
      ans_last  = 1'b0;
      step();
      step();
      rst = 1'b0;
      sb.delete();
      done_cnt = 0;
   endtask

   // Drive wq; size/latency are wrong during the words and settle afterwards.
   task automatic send(input logic [31:0] size, input logic [31:0] lat);
      ans_size = 32'hBAD0_BAD0;
      ans_lat  = 32'hBAD1_BAD1;
      for (int i = 0; i < wq.size(); i++) begin
         ans_valid = 1'b1;
         ans_data  = wq[i];
         ans_last  = (i == wq.size() - 1);
         step();
      end
      ans_valid = 1'b0;
      ans_last  = 1'b0;
      ans_size  = size;
      ans_lat   = lat;
   endtask

   task automatic make_words(input int n);
      wq.delete();
      for (int i = 0; i < n; i++)
         wq.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
   endtask

   task automatic exp_hdr(input logic [31:0] size, input logic [31:0] lat);
      sb.push_back(8'hA5);
      for (int i = 0; i < 4; i++) sb.push_back(size[8*i +: 8]);
      for (int i = 0; i < 4; i++) sb.push_back(lat[8*i +: 8]);
   endtask

   task automatic exp_seq(input int start, input int n);
      for (int i = 0; i < n; i++) sb.push_back(8'(start + i));
   endtask

   task automatic exp_csum(input logic [7:0] c);
`ifdef TASK_FRAMER_CHECKSUM_EN
      sb.push_back(c);
`else
      if (c == 8'h00) sb.push_back(8'h00);
`endif
   endtask

   task automatic wait_frame(input string name);
      logic seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         if (m_done) seen = 1'b1;
      end
      check({name, "_done_seen"}, seen, 1'b1);
      repeat (3) @(negedge clk);
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_bytes_left"}, sb.size(), 0);
      check({name, "_idle"}, m_busy, 1'b0);
   endtask

   initial begin
      sel = 1'b0; toggle = 1'b0; tx_ready = 1'b1;
      ans_data = '0; ans_size = '0; ans_lat = '0;
      do_reset();

      @(negedge clk);
      check("rst_valid", a_tx_valid, 1'b0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_ovf", a_ovf, 1'b0);
      check("rst_done", a_done, 1'b0);
      check("rst_data", a_tx_data, 8'h00);
      check("rst_b_valid", b_tx_valid, 1'b0);
      check("rst_fifo", dut_a.fifo_count, 0);

      // 8 words, size 32: header + 32 ascending payload bytes.
      step();
      done_cnt = 0;
      make_words(8);
      exp_hdr(32, 32'h123); exp_seq(0, 32); exp_csum(8'h02);
      send(32, 32'h123);
      wait_frame("s1");
      check("s1_ovf", a_ovf, 1'b0);

      // Partial final word: 77 and 88 must never appear; first byte after 2 cycles.
      step();
      done_cnt = 0;
      wq.delete(); wq.push_back(32'h4433_2211); wq.push_back(32'h8877_6655);
      exp_hdr(6, 32'h10);
      sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
      sb.push_back(8'h44); sb.push_back(8'h55); sb.push_back(8'h66);
      exp_csum(8'h61);
      send(6, 32'h10);
      @(negedge clk); check("s2_latch_valid", a_tx_valid, 1'b0);
      check("s2_latch_busy", a_busy, 1'b1);
      @(negedge clk); check("s2_hdr_valid", a_tx_valid, 1'b0);
      @(negedge clk); check("s2_first_valid", a_tx_valid, 1'b1);
      wait_frame("s2");

      // Scenario 1 again under a 1-0-0-1 ready pattern.
      step();
      done_cnt = 0;
      toggle = 1'b1;
      make_words(8);
      exp_hdr(32, 32'h123); exp_seq(0, 32); exp_csum(8'h02);
      send(32, 32'h123);
      wait_frame("s3");
      toggle = 1'b0;
      tx_ready = 1'b1;

      // Depth-4 DUT, 5 words: fifth dropped, size clamped 20 -> 16.
      step();
      sel = 1'b1;
      done_cnt = 0;
      make_words(5);
      exp_hdr(16, 32'h5); exp_seq(0, 16); exp_csum(8'h15);
      send(20, 32'h5);
      wait_frame("s4");
      check("s4_ovf", b_ovf, 1'b1);
      check("s4_fifo", dut_b.fifo_count, 0);
      sel = 1'b0;

      // Second answer arriving mid-payload: its last is dropped, words queued.
      do_reset();
      wq.delete(); wq.push_back(32'h4433_2211); wq.push_back(32'h8877_6655);
      exp_hdr(8, 32'h7);
      sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); sb.push_back(8'h44);
      sb.push_back(8'h55); sb.push_back(8'h66); sb.push_back(8'h77); sb.push_back(8'h88);
      exp_csum(8'h87);
      send(8, 32'h7);
      repeat (11) step();
      check("s5_busy_mid", a_busy, 1'b1);
      check("s5_ovf_before", a_ovf, 1'b0);
      wq.delete(); wq.push_back(32'hC0C0_0001); wq.push_back(32'hC0C0_0002);
      wq.push_back(32'hC0C0_0003);
      send(12, 32'h99);
      wait_frame("s5");
      check("s5_ovf", a_ovf, 1'b1);
      check("s5_fifo_queued", dut_a.fifo_count, 3);

      // Reset mid-payload, then a 1-word answer.
      do_reset();
      make_words(8);
      exp_hdr(32, 32'h123); exp_seq(0, 32);
      send(32, 32'h123);
      repeat (14) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      done_cnt = 0;
      @(negedge clk);
      check("s6_valid", a_tx_valid, 1'b0);
      check("s6_busy", a_busy, 1'b0);
      check("s6_fifo", dut_a.fifo_count, 0);
      check("s6_ovf", a_ovf, 1'b0);
      step();
      wq.delete(); wq.push_back(32'hDDCC_BBAA);
      exp_hdr(4, 32'h2);
      sb.push_back(8'hAA); sb.push_back(8'hBB); sb.push_back(8'hCC); sb.push_back(8'hDD);
      exp_csum(8'h06);
      send(4, 32'h2);
      wait_frame("s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/task_answer_uart_framer.md
Name: task_answer_uart_framer

Overview:
- Downstream neighbour of the task wrapper's answer interface.
- Consumes the 32-bit answer word stream plus the answer's byte size and latency, and buffers the answer words in a FIFO.
- After the last word it emits one byte-serial frame to the UART TX path: start byte, 4-byte size, 4-byte latency, payload bytes, then an optional checksum.
- The answer side has no backpressure (tready tied high upstream), so the framer must never stall the input.

Parameters:
- FIFO_DEPTH, 256, answer words buffered; power of two, ≥4.
- START_BYTE, 8'hA5, frame delimiter byte.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_answer_valid  input  1  answer word strobe.
- i_answer_data  input  32  answer word; byte 0 = bits [7:0].
- i_answer_last  input  1  marks the final word of an answer; qualified by valid.
- i_answer_size_in_bytes  input  32  answer byte count.
- i_answer_latency  input  32  task latency in cycles.
- o_tx_data  output  8  byte to UART TX.
- o_tx_valid  output  1  byte valid.
- i_tx_ready  input  1  UART TX accepts the byte.
- o_busy  output  1  high in any state other than COLLECT.
- o_overflow  output  1  sticky error flag.
- o_frame_done  output  1  one-cycle pulse after the final frame byte is accepted.

Behaviour:
- Reset:
  - All outputs 0; FIFO emptied; state COLLECT.
  - Latched size, latency and checksum cleared.
  - Reset mid-frame aborts the frame immediately; no partial byte is held.
- COLLECT:
  - Every valid word is written to the FIFO.
  - On a valid word with last set, go to LATCH.
- LATCH (1 cycle):
  - Capture i_answer_size_in_bytes and i_answer_latency. These are sampled exactly one cycle after the last word, because the upstream counters settle on the last word.
  - Clamp size to 4 × (FIFO word count).
  - Go to HDR.
- HDR:
  - Emit 9 bytes: START_BYTE, size[7:0], [15:8], [23:16], [31:24], then latency in the same little-endian order.
  - Then go to PAYLOAD, or to CSUM/DONE if the clamped size is 0.
- PAYLOAD:
  - Pop words and emit bytes LSB first; a byte counter decrements per accepted byte.
  - The final word may be partial: emit only the remaining (size mod 4, or 4) bytes, then discard the rest of that word.
  - Words left in the FIFO beyond size/4 rounded up are discarded before DONE.
- Handshake:
  - AXI-style. o_tx_data is held stable while o_tx_valid is high and i_tx_ready is low.
  - A byte advances only on valid && ready.
  - o_tx_valid may not depend combinationally on i_tx_ready.
- DONE:
  - Pulse o_frame_done, then return to COLLECT.
- Words arriving while o_busy is high:
  - They are written to the FIFO for the next answer, unless the FIFO is full.
  - Their FIFO count is tracked separately so the current frame's clamp is unaffected.
- Overflow:
  - A write attempted while the FIFO is full drops the word and sets o_overflow.
  - A last arriving while o_busy is high drops that answer's metadata and sets o_overflow.
  - o_overflow stays set until i_rst.
- Simultaneous push and pop on a full FIFO: the push succeeds.
- Latency to first byte: o_tx_valid rises 2 cycles after the last word is accepted (LATCH, then HDR registered).

Optional Feature:
- Macro: TASK_FRAMER_CHECKSUM_EN.
- Defined:
  - A CSUM state follows PAYLOAD and emits one byte: the XOR of every frame byte after START_BYTE (size, latency, payload).
  - The checksum register clears in LATCH.
- Undefined: no CSUM state; the frame ends after the last payload byte; no checksum logic is synthesised.

Decomposition:
- Package task_framer_pkg holds:
  - state enum: COLLECT, LATCH, HDR, PAYLOAD, CSUM, DONE;
  - HDR_BYTES = 9;
  - default START_BYTE.
- One sub-module, framer_word_fifo:
  - synchronous 32-bit FIFO with count output;
  - first-word-fall-through.

Test Plan:
- 8 words, size = 32, latency = 0x0000_0123, tx_ready always 1 → bytes A5, 20 00 00 00, 23 01 00 00, then 32 payload bytes LSB-first; o_frame_done pulses once; frame length 41 bytes, or 42 bytes when TASK_FRAMER_CHECKSUM_EN is defined.
- 2 words 0x44332211 and 0x88776655, size = 6 → payload 11 22 33 44 55 66; bytes 77 and 88 are never emitted.
- Same stimulus as the first scenario with i_tx_ready toggling 1-0-0-1 → o_tx_data stable during stalls; byte sequence identical to the first scenario.
- FIFO_DEPTH = 4 with 5 words pushed → o_overflow = 1; size clamped to 16; 16 payload bytes sent.
- A second 3-word answer (last included) arrives during the first frame's payload → the second answer's last is dropped with o_overflow = 1; its 3 words are queued in the FIFO and the first frame is unchanged.
- i_rst asserted mid-PAYLOAD → next cycle o_tx_valid = 0, o_busy = 0, FIFO empty; a following 1-word answer frames correctly.
